// File: rtl/fan_speed_pkg.sv
// Shared widths and constants for the fan PWM block.
package fan_speed_pkg;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
  localparam int              KICK_W  = 4;

endpackage

// File: rtl/fan_speed_tick.sv
// Prescaler: emits a one-cycle step enable every PRESCALE clk cycles.
module fan_speed_tick #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic arst,
  output logic step
);

  // Keep at least one bit so PRESCALE=1 still elaborates cleanly.
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  assign step = (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst)     pre_q <= '0;
    else if (step) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;
  end

endmodule

// File: rtl/fan_speed.sv
// Fan PWM generator: 256-step period, duty latched at period start.
// Optional kick-start (full drive for KICK_PERIODS periods from standstill) under FAN_KICKSTART_EN.
module fan_speed
  import fan_speed_pkg::*;
#(
  parameter int PRESCALE     = 1,
  parameter int KICK_PERIODS = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [CNT_W-1:0] speed,
  output logic             pwm_data
);

  logic             step;
  logic             boundary;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_q;

  fan_speed_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .arst (arst),
    .step (step)
  );

  // The step that wraps cnt 255->0 is the only point where speed is sampled.
  assign boundary = step && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt    <= '0;
      duty_q <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (boundary) duty_q <= speed;
    end
  end

`ifdef FAN_KICKSTART_EN
  logic [KICK_W-1:0] kick_q;

  // kick_q holds the number of full-drive periods still to run.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      kick_q <= '0;
    end else if (boundary) begin
      if (speed != '0 && duty_q == '0) kick_q <= KICK_W'(KICK_PERIODS);
      else if (speed == '0)            kick_q <= '0;
      else if (kick_q != '0)           kick_q <= kick_q - 1'b1;
    end
  end

  assign pwm_data = (kick_q != '0) || (cnt < duty_q);
`else
  assign pwm_data = (cnt < duty_q);
`endif

endmodule

// File: tb/tb_fan_speed.sv
// Randomized bench for fan_speed: two instances (PRESCALE 1 and 4) against a period-level model.
module tb_fan_speed;

  localparam int KP = 4;

  logic       clk   = 1'b0;
  logic       arst  = 1'b0;
  logic [7:0] speed = 8'd0;
  logic       pwm1, pwm4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fan_speed #(.PRESCALE(1), .KICK_PERIODS(KP)) u_dut1 (
    .clk(clk), .arst(arst), .speed(speed), .pwm_data(pwm1));
  fan_speed #(.PRESCALE(4), .KICK_PERIODS(KP)) u_dut4 (
    .clk(clk), .arst(arst), .speed(speed), .pwm_data(pwm4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: elapsed clk cycles since reset release determine the step and period;
  // each period's duty is the speed seen on the last cycle of the previous period.
  int ps   [2] = '{1, 4};
  int t    [2] = '{0, 0};
  int duty [2] = '{0, 0};
  int kick [2] = '{0, 0};

  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < 2; i++) begin t[i] = 0; duty[i] = 0; kick[i] = 0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((t[i] + 1) % (256 * ps[i]) == 0) begin
`ifdef FAN_KICKSTART_EN
          if (speed != 0 && duty[i] == 0) kick[i] = KP;
          else if (speed == 0)            kick[i] = 0;
          else if (kick[i] > 0)           kick[i] = kick[i] - 1;
`endif
          duty[i] = speed;
        end
        t[i] = t[i] + 1;
      end
    end
  end

  function automatic logic exp_pwm(input int i);
    return (kick[i] > 0) || (((t[i] / ps[i]) % 256) < duty[i]);
  endfunction

  always @(negedge clk) begin
    chk("pwm_p1", 32'(pwm1), 32'(exp_pwm(0)));
    chk("pwm_p4", 32'(pwm4), 32'(exp_pwm(1)));
  end

  int h1 [8];
  int h4 [2];

  initial begin
    // Reset held: outputs low regardless of clk.
    speed = 8'd64;
    repeat (3) @(negedge clk);
    chk("rst_p1", 32'(pwm1), 32'd0);
    chk("rst_p4", 32'(pwm4), 32'd0);

    // Directed high-count per period after release with speed=64.
    arst = 1'b1;
    for (int i = 0; i < 8; i++) h1[i] = 0;
    for (int i = 0; i < 2; i++) h4[i] = 0;
    for (int i = 0; i < 2048; i++) begin
      h1[i / 256]  += int'(pwm1);
      h4[i / 1024] += int'(pwm4);
      @(negedge clk);
    end
    chk("first_period_p1", 32'(h1[0]), 32'd0);
    chk("first_period_p4", 32'(h4[0]), 32'd0);
    for (int i = 1; i < 8; i++) begin
`ifdef FAN_KICKSTART_EN
      chk("high_count_p1", 32'(h1[i]), (i <= KP) ? 32'd256 : 32'd64);
`else
      chk("high_count_p1", 32'(h1[i]), 32'd64);
`endif
    end
`ifdef FAN_KICKSTART_EN
    chk("high_count_p4", 32'(h4[1]), 32'd1024);
`else
    chk("high_count_p4", 32'(h4[1]), 32'd256);
`endif

    // Stop, then full speed; the 255/1 split is checked by the model.
    speed = 8'd0;
    repeat (2048) @(negedge clk);
    speed = 8'd255;
    repeat (4096) @(negedge clk);

    // Mid-period change is deferred to the next boundary.
    speed = 8'd64;
    repeat (1024 + 10) @(negedge clk);
    speed = 8'd128;
    repeat (1024) @(negedge clk);

    // Prescaled case and then random speeds with frequent stops.
    speed = 8'd32;
    repeat (3072) @(negedge clk);
    for (int n = 0; n < 30; n++) begin
      speed = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      repeat ($urandom_range(1, 600)) @(negedge clk);
    end

    // Async reset between clock edges must drop the output at once.
    speed = 8'd64;
    repeat (256 * 6 + 30) @(negedge clk);
    @(posedge clk);
    #2 arst = 1'b0;
    #1;
    chk("async_rst_p1", 32'(pwm1), 32'd0);
    chk("async_rst_p4", 32'(pwm4), 32'd0);
    @(negedge clk);
    arst = 1'b1;
    repeat (2048) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
